mem_arbiter: RTL and testbench

- Shares the single unified main memory below the I-cache and D-cache between two requesters: I-cache line fills and D-cache fills/write-backs.
- Sits inside the memory hierarchy, between the two cache controllers and main memory.
- Fixed priority: D over I. The pipeline is stalled on any miss, so I cannot starve.
- Also keeps saturating per-requester transaction counters and a watchdog for a hung memory.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_sat_counter.sv | 19 +
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory arbiter and the cache controllers:
// arbiter states, owner encoding and default geometry of the memory port.
package mem_pkg;

  localparam int BLK_ADDR_W  = 14;
  localparam int LINE_W      = 64;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC,
    RECOVER
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  function automatic owner_t owner_of(state_t s);
    return (s == D_ACC) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory handshakes seen by the arbiter.
// slave = arbiter side, master = caches plus memory side.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = BLK_ADDR_W,
  parameter int DATA_W = LINE_W
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              m_re;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rdy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_rdy,
    output i_ack, i_rdata, d_ack, d_rdata, m_re, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_rdy,
    input  i_ack, i_rdata, d_ack, d_rdata, m_re, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared asynchronously.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (D over I) arbiter for the unified main memory, with a
// watchdog for a hung memory and saturating per-requester statistics.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = BLK_ADDR_W,
  parameter int DATA_W  = LINE_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic             err,
  output logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] d_rd_cnt,
  output logic [CNT_W-1:0] d_wr_cnt
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              m_re_reg, m_re_next, m_we_reg, m_we_next;
  logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
  logic [DATA_W-1:0] i_rdata_reg, i_rdata_next, d_rdata_reg, d_rdata_next;
  logic              i_ack_reg, i_ack_next, d_ack_reg, d_ack_next;
  logic              err_reg, err_next;
  logic [WD_W-1:0]   wdog_reg, wdog_next;
  logic              in_acc, done, expired;
  owner_t            owner;
  logic [2:0]        inc_vec;
  logic [CNT_W-1:0]  cnt_vec [3];

  assign in_acc  = (state_reg == I_ACC) || (state_reg == D_ACC);
  assign done    = in_acc && bus.m_rdy;
  assign expired = in_acc && !bus.m_rdy && (wdog_reg == WD_LAST);
  assign owner   = owner_of(state_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      m_re_reg    <= 1'b0;
      m_we_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
      i_ack_reg   <= 1'b0;
      d_ack_reg   <= 1'b0;
      err_reg     <= 1'b0;
      wdog_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      m_re_reg    <= m_re_next;
      m_we_reg    <= m_we_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
      i_ack_reg   <= i_ack_next;
      d_ack_reg   <= d_ack_next;
      err_reg     <= err_next;
      wdog_reg    <= wdog_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.d_req) begin
          state_next = D_ACC;
        end else if (bus.i_req) begin
          state_next = I_ACC;
        end
      end
      I_ACC, D_ACC: begin
        if (done || expired) begin
          state_next = RECOVER;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RECOVER falls through with all defaults: strobes low, no grant, so a
  // requester still holding req after its ack is not re-served.
  always_comb begin
    m_re_next    = 1'b0;
    m_we_next    = 1'b0;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    i_ack_next   = 1'b0;
    d_ack_next   = 1'b0;
    err_next     = err_reg;
    wdog_next    = '0;
    case (state_reg)
      IDLE: begin
        if (bus.d_req) begin
          m_addr_next  = bus.d_addr;
          m_wdata_next = bus.d_wdata;
          m_we_next    = bus.d_we;
          m_re_next    = !bus.d_we;
        end else if (bus.i_req) begin
          m_addr_next = bus.i_addr;
          m_re_next   = 1'b1;
        end
      end
      I_ACC, D_ACC: begin
        if (done || expired) begin
          i_ack_next = (owner == OWN_I);
          d_ack_next = (owner == OWN_D);
          if (expired) begin
            err_next = 1'b1;
            if (owner == OWN_I) i_rdata_next = '0;
            else                d_rdata_next = '0;
          end else if (m_re_reg) begin
            if (owner == OWN_I) i_rdata_next = bus.m_rdata;
            else                d_rdata_next = bus.m_rdata;
          end
        end else begin
          m_re_next = m_re_reg;
          m_we_next = m_we_reg;
          wdog_next = wdog_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Only successful completions are counted; a watchdog abort is not.
  assign inc_vec[0] = done && (owner == OWN_I);
  assign inc_vec[1] = done && (owner == OWN_D) && !m_we_reg;
  assign inc_vec[2] = done && (owner == OWN_D) && m_we_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    sat_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk (clk),
      .clr (rst),
      .inc (inc_vec[gi]),
      .cnt (cnt_vec[gi])
    );
  end

  assign i_cnt    = cnt_vec[0];
  assign d_rd_cnt = cnt_vec[1];
  assign d_wr_cnt = cnt_vec[2];

  assign bus.m_re    = m_re_reg;
  assign bus.m_we    = m_we_reg;
  assign bus.m_addr  = m_addr_reg;
  assign bus.m_wdata = m_wdata_reg;
  assign bus.i_ack   = i_ack_reg;
  assign bus.i_rdata = i_rdata_reg;
  assign bus.d_ack   = d_ack_reg;
  assign bus.d_rdata = d_rdata_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random transactions against a
// transaction-level model of memory contents, grant order, counters and err.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          err;
  logic [CW-1:0] i_cnt, d_rd_cnt, d_wr_cnt;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .err      (err),
    .i_cnt    (i_cnt),
    .d_rd_cnt (d_rd_cnt),
    .d_wr_cnt (d_wr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // environment knobs
  int mem_lat = 1;
  bit spur_en = 1'b0;

  // model state
  int          exp_cnt [3];
  bit          exp_err;
  logic [DW-1:0] exp_irdata, exp_drdata;
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] init_val(int a);
    return {32'(a) * 32'h9E3779B1, 32'(a) ^ 32'h5A5A0000};
  endfunction

  function automatic logic [DW-1:0] model_read(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: m_rdy in the mem_lat-th strobe cycle, optional noise when idle.
  initial begin : responder
    logic [DW-1:0] mem [int];
    int str_cnt;
    int a;
    str_cnt     = 0;
    bus.m_rdy   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_rdata = {$urandom, $urandom};
      if (bus.m_re || bus.m_we) begin
        str_cnt++;
        a = int'(bus.m_addr);
        if (str_cnt == mem_lat) begin
          bus.m_rdy = 1'b1;
          if (bus.m_we) mem[a] = bus.m_wdata;
          else bus.m_rdata = mem.exists(a) ? mem[a] : init_val(a);
        end else begin
          bus.m_rdy = 1'b0;
        end
      end else begin
        str_cnt   = 0;
        bus.m_rdy = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic wait_ack(input bit is_d, input logic [AW-1:0] addr, input logic [1:0] str,
                          input logic [DW-1:0] wdata, input int n_exp, input int lead,
                          input bit scramble);
    bit seen;
    seen = 1'b0;
    for (int k = 1; k <= TO + 20 && !seen; k++) begin
      @(negedge clk);
      if (scramble && k == lead + 1) begin
        if (is_d) begin
          bus.d_addr  = AW'($urandom);
          bus.d_wdata = {$urandom, $urandom};
          if ($urandom_range(0, 1) == 1) bus.d_req = 1'b0;
        end else begin
          bus.i_addr = AW'($urandom);
          if ($urandom_range(0, 1) == 1) bus.i_req = 1'b0;
        end
      end
      check("other_ack", is_d ? bus.i_ack : bus.d_ack, 0);
      if ((is_d ? bus.d_ack : bus.i_ack) === 1'b1) begin
        seen = 1'b1;
        check("latency", k, n_exp);
      end else if (k <= lead) begin
        check("lead_strobes", {bus.m_re, bus.m_we}, 0);
      end else begin
        check("strobes", {bus.m_re, bus.m_we}, str);
        check("m_addr", bus.m_addr, addr);
        if (str == 2'b01) check("m_wdata", bus.m_wdata, wdata);
      end
    end
    check("ack_seen", seen, 1);
  endtask

  // kind: 0 = I fill, 1 = D fill, 2 = D write-back
  task automatic finish_txn(input int kind, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input bit to);
    logic [DW-1:0] exp_rd;
    check("strobes_off", {bus.m_re, bus.m_we}, 0);
    if (to) begin
      exp_err = 1'b1;
      exp_rd  = '0;
    end else begin
      if (exp_cnt[kind] < (1 << CW) - 1) exp_cnt[kind]++;
      if (kind == 2) begin
        ref_mem[int'(addr)] = wdata;
        exp_rd = exp_drdata;
      end else begin
        exp_rd = model_read(int'(addr));
      end
    end
    if (kind == 0) begin
      exp_irdata = exp_rd;
      bus.i_req  = 1'b0;
      check("i_rdata", bus.i_rdata, exp_irdata);
      check("d_rdata_hold", bus.d_rdata, exp_drdata);
    end else begin
      exp_drdata = exp_rd;
      bus.d_req  = 1'b0;
      check("d_rdata", bus.d_rdata, exp_drdata);
      check("i_rdata_hold", bus.i_rdata, exp_irdata);
    end
    check("err", err, exp_err);
    check("i_cnt", i_cnt, exp_cnt[0]);
    check("d_rd_cnt", d_rd_cnt, exp_cnt[1]);
    check("d_wr_cnt", d_wr_cnt, exp_cnt[2]);
  endtask

  task automatic txn(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int lat, input bit scramble);
    bit to;
    to      = (lat < 1) || (lat > TO);
    mem_lat = lat;
    @(negedge clk);
    if (kind == 0) begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = (kind == 2);
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end
    wait_ack(kind != 0, addr, (kind == 2) ? 2'b01 : 2'b10, wdata, to ? TO + 1 : lat + 1, 0, scramble);
    finish_txn(kind, addr, wdata, to);
    @(negedge clk);
    check("ack_pulse", {bus.i_ack, bus.d_ack}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {bus.m_re, bus.m_we}, 0);
    check({tag, "_acks"}, {bus.i_ack, bus.d_ack}, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cnts"}, {i_cnt, d_rd_cnt, d_wr_cnt}, 0);
    check({tag, "_rdata"}, bus.i_rdata | bus.d_rdata, 0);
  endtask

  initial begin
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    exp_cnt     = '{0, 0, 0};
    exp_err     = 1'b0;
    exp_irdata  = '0;
    exp_drdata  = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_m_addr", bus.m_addr, 0);
    rst = 1'b0;

    // single I fill, latency 4
    txn(0, 14'h0012, '0, 4, 1'b0);

    // simultaneous requests: D first, I after D's recover cycle
    mem_lat = 3;
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 14'h0040;
    bus.i_req  = 1'b1;
    bus.i_addr = 14'h0123;
    wait_ack(1'b1, 14'h0040, 2'b10, '0, 4, 0, 1'b0);
    finish_txn(1, 14'h0040, '0, 1'b0);
    wait_ack(1'b0, 14'h0123, 2'b10, '0, 5, 1, 1'b0);
    finish_txn(0, 14'h0123, '0, 1'b0);
    @(negedge clk);
    check("pair_ack_pulse", {bus.i_ack, bus.d_ack}, 0);

    // write-back then fill of the same line
    txn(2, 14'h0077, 64'hDEADBEEFCAFE1234, 3, 1'b0);
    txn(1, 14'h0077, '0, 2, 1'b0);
    check("wb_readback", exp_drdata, 64'hDEADBEEFCAFE1234);

    // random traffic with idle-time m_rdy noise and mid-access input changes
    spur_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      txn($urandom_range(0, 2), AW'($urandom_range(0, 15)), {$urandom, $urandom},
          $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end
    spur_en = 1'b0;

    // watchdog: memory never answers
    txn(1, 14'h0100, '0, 0, 1'b0);
    txn(0, 14'h0005, '0, 2, 1'b0);

    // asynchronous reset in the middle of a D access, I pending
    mem_lat = 6;
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 14'h0200;
    bus.i_req  = 1'b1;
    bus.i_addr = 14'h0033;
    repeat (3) @(negedge clk);
    check("pre_rst_strobes", {bus.m_re, bus.m_we}, 2'b10);
    #1 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_cnt    = '{0, 0, 0};
    exp_err    = 1'b0;
    exp_irdata = '0;
    exp_drdata = '0;
    bus.d_req  = 1'b0;
    mem_lat    = 3;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(1'b0, 14'h0033, 2'b10, '0, 4, 0, 1'b0);
    finish_txn(0, 14'h0033, '0, 1'b0);
    @(negedge clk);
    check("post_rst_ack_pulse", {bus.i_ack, bus.d_ack}, 0);

    // saturation of the I counter
    for (int n = 0; n < 17; n++) begin
      txn(0, AW'($urandom_range(0, 63)), '0, 1, 1'b0);
    end
    check("i_cnt_sat", i_cnt, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
